// File: rtl/seq_det_pkg.sv
// Shared types, mode constants and sizing helper for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } seq_state_e;

    localparam logic MODE_OVERLAP    = 1'b1;
    localparam logic MODE_NONOVERLAP = 1'b0;

    // Width needed to count 0..seq_len inclusive.
    function automatic int fill_width(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Parametrised shift register with enable and synchronous clear; newest bit enters at the LSB.
module seq_shift_reg #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Truncating {q, sin} drops the oldest bit and also covers WIDTH == 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= WIDTH'({q, sin});
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with registered match pulse and optional saturating match counter.
// Build option: define SEQDET_CNT_EN to build the match_cnt counter; otherwise match_cnt is tied to 0.
//
// state    | meaning
// ST_FILL  | fewer than SEQ_LEN bits accepted since reset, clear or non-overlap hit
// ST_ARMED | SEQ_LEN bits accepted; the window is eligible to match
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             din,
    input  logic             overlap,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                FILL_W   = fill_width(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(SEQ_LEN - 1);

    seq_state_e          state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                match_d;
    logic                accept;
    logic                hit;
    logic [SEQ_LEN-2:0]  hist_tail;
    logic [SEQ_LEN-1:0]  window;

    assign accept = in_valid & ~clear;

    // The oldest history bit only ever shifts out, so just the younger SEQ_LEN-1 bits are stored.
    seq_shift_reg #(
        .WIDTH (SEQ_LEN - 1)
    ) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .clr   (clear),
        .sin   (din),
        .q     (hist_tail)
    );

    assign window = {hist_tail, din};
    assign hit    = accept && (window == PATTERN) && (fill_q >= FILL_HIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            match   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            match   <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (clear) begin
            state_d = ST_FILL;
            fill_d  = '0;
        end else if (in_valid) begin
            match_d = hit;
            if (hit && (overlap == MODE_NONOVERLAP)) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
            state_d = (fill_d == FILL_MAX) ? ST_ARMED : ST_FILL;
        end
    end

`ifdef SEQDET_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (clear) begin
            match_cnt <= '0;
        end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: two detector instances (1011/len4/cnt8 and 11/len2/cnt2) against a window-based reference model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       din = 1'b0;
    logic       overlap = 1'b1;
    logic       clear = 1'b0;
    logic       match_a, match_b;
    logic [7:0] match_cnt_a;
    logic [1:0] match_cnt_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] win;
        int          since;
        int          cnt;
        bit          m;
    } mdl_t;

    typedef struct {
        bit ma;
        int ca;
        bit mb;
        int cb;
    } exp_t;

    exp_t exp_q[$];
    mdl_t ma_s, mb_s;
    int   cyc_n = 0;

    always #5 clk = ~clk;

    seq_detect_param dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din       (din),
        .overlap   (overlap),
        .clear     (clear),
        .match     (match_a),
        .match_cnt (match_cnt_a)
    );

    seq_detect_param #(
        .SEQ_LEN (2),
        .PATTERN (2'b11),
        .CNT_W   (2)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din       (din),
        .overlap   (overlap),
        .clear     (clear),
        .match     (match_b),
        .match_cnt (match_cnt_b)
    );

    // Reference: the last len accepted bits form the window; a match needs len bits since the last boundary.
    function automatic mdl_t mstep(mdl_t s, int len, logic [31:0] pat, int cmax,
                                   bit v, bit d, bit ov, bit clr);
        mdl_t        n;
        logic [31:0] mask;
        n = s;
        n.m = 1'b0;
        mask = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
        if (clr) begin
            n.win = 32'd0;
            n.since = 0;
            n.cnt = 0;
        end else if (v) begin
            n.win = ((s.win << 1) | 32'(d)) & mask;
            n.since = s.since + 1;
            if (n.win == pat && s.since + 1 >= len) begin
                n.m = 1'b1;
                if (n.cnt < cmax) n.cnt = n.cnt + 1;
                if (!ov) n.since = 0;
            end
        end
        return n;
    endfunction

    function automatic mdl_t mreset();
        mdl_t n;
        n.win = 32'd0;
        n.since = 0;
        n.cnt = 0;
        n.m = 1'b0;
        return n;
    endfunction

    function automatic int exp_cnt(int c);
`ifdef SEQDET_CNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_n, got, expv);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.ma = ma_s.m;
        e.ca = exp_cnt(ma_s.cnt);
        e.mb = mb_s.m;
        e.cb = exp_cnt(mb_s.cnt);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit v, input bit d, input bit ov, input bit clr);
        @(negedge clk);
        in_valid = v;
        din = d;
        overlap = ov;
        clear = clr;
        ma_s = mstep(ma_s, 4, 32'hB, 255, v, d, ov, clr);
        mb_s = mstep(mb_s, 2, 32'h3, 3, v, d, ov, clr);
        push_exp();
    endtask

    task automatic stream(input logic [31:0] bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], ov, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        clear = 1'b0;
        #1;
        chk("rst_a_match", int'(match_a), 0);
        chk("rst_a_cnt", int'(match_cnt_a), 0);
        chk("rst_b_match", int'(match_b), 0);
        chk("rst_b_cnt", int'(match_cnt_b), 0);
        ma_s = mreset();
        mb_s = mreset();
        push_exp();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per cycle in which the driver issued stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("a_match", int'(match_a), int'(e.ma));
                chk("a_cnt", int'(match_cnt_a), e.ca);
                chk("b_match", int'(match_b), int'(e.mb));
                chk("b_cnt", int'(match_cnt_b), e.cb);
            end
        end
    end

    initial begin
        bit ov_r;
        ma_s = mreset();
        mb_s = mreset();
        #1;
        chk("por_a_match", int'(match_a), 0);
        chk("por_a_cnt", int'(match_cnt_a), 0);
        chk("por_b_match", int'(match_b), 0);
        chk("por_b_cnt", int'(match_cnt_b), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        stream(32'b1011011, 7, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        stream(32'b1011011, 7, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        stream(32'b101, 3, 1'b1);
        repeat (5) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        stream(32'b101, 3, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        stream(32'b1011, 4, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        stream(32'hFF, 8, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        stream(32'b101, 3, 1'b1);
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        ov_r = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) ov_r = ~ov_r;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ov_r,
                    $urandom_range(0, 59) == 0);
            end
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
